// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit. Optional multiply-accumulate is
// enabled by defining MD_UNIT_MADD_EN.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MADDU = 3'd7;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_unit_arith.sv
// md_arith: combinational {hi,lo} result generator from latched op/operands and the
// current HI/LO pair (used as the accumulator base for MADD/MADDU).
module md_arith
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] sr;
    logic [W2-1:0]    res;

    // Products: sign-extended operands give the signed product in the low 2*WIDTH bits.
    always_comb begin
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    // Signed divide by magnitudes; remainder follows the dividend's sign.
    always_comb begin
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
        uq    = (mag_b == '0) ? ALL_ONES : mag_a / mag_b;
        ur    = (mag_b == '0) ? a        : mag_a % mag_b;
        sq    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq : uq;
        sr    = a[WIDTH-1] ? -ur : ur;
    end

    // Result select, including divide-by-zero and signed-overflow corner cases.
    always_comb begin
        res = {hi, lo};
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                if (b == '0)
                    res = {a, ALL_ONES};
                else if (a == MOST_NEG && b == ALL_ONES)
                    res = {{WIDTH{1'b0}}, MOST_NEG};
                else
                    res = {sr, sq};
            end
            MD_DIVU: begin
                if (b == '0)
                    res = {a, ALL_ONES};
                else
                    res = {a % b, a / b};
            end
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            default:  res = {hi, lo};
        endcase
    end

    assign res_hi = res[W2-1:WIDTH];
    assign res_lo = res[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Define MD_UNIT_MADD_EN to accept MADD/MADDU (ops 6/7).
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             md_op;
    logic             mult_op;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Decode which incoming ops start a multi-cycle run and which latency applies.
    always_comb begin
`ifdef MD_UNIT_MADD_EN
        md_op   = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU) ||
                  (op == MD_MADD) || (op == MD_MADDU);
`else
        md_op   = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif
        mult_op = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
    end

    // Next-state, counter, operand latch and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    if (md_op) begin
                        state_d = MD_RUN;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = mult_op ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d == MD_RUN);
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passed = 0;
    int n;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive one start pulse across exactly one rising edge; returns just after the next negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = '0; b = '0;
    endtask

    // Count negedge samples with busy high, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cyc);
        for (int i = 0; i < cyc; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'd1);

        // DIVU 7 / 0
        issue(3'd3, 32'd7, 32'd0);
        wait_idle(n);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd7);

        // DIV -5 / 0
        issue(3'd2, 32'hFFFF_FFFB, 32'd0);
        wait_idle(n);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'hFFFF_FFFB);

        // DIV most-negative / -1
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'h0);

        // MTHI: immediate, no busy
        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h8000_0000);

        // MULTU with an ignored start 3 cycles into the run
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        idle(2);
        issue(3'd0, 32'd5, 32'd5);
        wait_idle(n);
        check("multu_rem_cycles", 32'(n), 32'd2);
        check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'd0);
        idle(1);
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_lo", lo, 32'd0);

        // MTHI then MULT on consecutive edges
        issue(3'd4, 32'hAAAA_5555, 32'd0);
        issue(3'd0, 32'd3, 32'd4);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("b2b_cycles", 32'(n), 32'd5);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd12);

        // DIV flushed on its 4th cycle
        issue(3'd2, 32'd100, 32'd7);
        idle(3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'd12);
        idle(12);
        check("flush_late_lo", lo, 32'd12);
        check("flush_late_busy", 32'(busy), 32'd0);

        // Start together with flush
        flush = 1'b1;
        issue(3'd0, 32'd2, 32'd2);
        flush = 1'b0;
        check("sflush_busy", 32'(busy), 32'd0);
        flush = 1'b1;
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b0;
        check("sflush_mtlo_lo", lo, 32'd12);

        // Reset mid-MULT
        issue(3'd0, 32'd3, 32'd3);
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        idle(8);
        check("rst_late_lo", lo, 32'd0);
        check("rst_late_busy", 32'(busy), 32'd0);

        // MADDU 1*1 onto {0, 0xFFFFFFFF}
        issue(3'd5, 32'hFFFF_FFFF, 32'd0);
        issue(3'd7, 32'd1, 32'd1);
`ifdef MD_UNIT_MADD_EN
        check("maddu_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("maddu_cycles", 32'(n), 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        issue(3'd6, 32'hFFFF_FFFF, 32'd1);
        wait_idle(n);
        check("madd_hi", hi, 32'd0);
        check("madd_lo", lo, 32'hFFFF_FFFF);
`else
        check("maddu_off_busy", 32'(busy), 32'd0);
        idle(6);
        check("maddu_off_busy2", 32'(busy), 32'd0);
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core, sitting beside the ALU. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse and models the MIPS HI/LO register pair. It holds `busy` for a configurable latency so the hazard unit can stall MFHI/MFLO and following MD ops. A `flush` input cancels an in-flight operation when an interrupt or exception is taken.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `MULT_CYCLES`, 5: cycles from accepted start to HI/LO update for multiply ops; minimum 1.
- `DIV_CYCLES`, 10: same for divide ops; minimum 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled each edge.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  cancel in-flight op; asserted by the interrupt/exception logic.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN. A down-counter is loaded with latency−1 on entry to RUN.
- IDLE with `start`, op 0–3 (or 6–7 when enabled):
  - Latch `op` and the operands.
  - Go to RUN.
- IDLE with `start`, op 4/5: write `a` into HI/LO at that edge; stay IDLE; `busy` stays 0.
- RUN:
  - Decrement each edge. At the final edge, load HI/LO and return to IDLE.
  - Multiply: {HI,LO} = 2·WIDTH product, signed (0) or unsigned (1).
  - Divide: LO = quotient, HI = remainder; signed remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = `a`.
- Signed overflow (most-negative / −1): LO = most-negative value, HI = 0.
- `start` while `busy`=1 is ignored; the hazard unit must stall the requester.
- `flush`:
  - In RUN: return to IDLE at the next edge; HI/LO keep their pre-operation values.
  - Together with `start`: `flush` wins and `start` is ignored.
  - In IDLE: no effect.
- `reset` has priority over everything. It forces IDLE, `busy`=0, `hi`=0, `lo`=0, and counter=0, including mid-operation.

## Timing
- `start` accepted at edge E:
  - `busy`=1 after E.
  - At edge E+MULT_CYCLES (or E+DIV_CYCLES), `hi`/`lo` take the result and `busy` returns to 0.
  - A new `start` can be accepted at that same edge's following cycle, i.e. at edge E+N+1.
- MTHI/MTLO: `hi`/`lo` visible one cycle after the accepting edge; zero busy cycles.
- `hi`, `lo`, `busy` are registered outputs with no combinational path from inputs.
- Back-to-back MTHI then MULT on consecutive edges is legal. The MULT result overwrites both registers.

## Configuration
- `MD_UNIT_MADD_EN`:
  - Defined: op 6/7 accepted. {HI,LO} += signed (6) / unsigned (7) product of `a`,`b`, with 2·WIDTH wrap-around and MULT_CYCLES latency. The accumulate uses the HI/LO values at the completion edge.
  - Undefined: op 6/7 with `start` are ignored. No state change, `busy` stays 0.

## Structure
- Package `md_pkg`: op code localparams (`MD_MULT` … `MD_MADDU`) and state encoding.
- One natural sub-module: `md_arith`, a combinational generator of the {hi,lo} result from latched op/operands/current HI/LO.
- `md_unit` holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3 → `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=−7, b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- MTHI a=0x12345678, then MULTU a=0x10000, b=0x10000 started 3 cycles into its run:
  - The start during busy is ignored.
  - The next accepted MULTU gives hi=1, lo=0.
- DIV started, `flush` on cycle 4 → `busy`=0 next cycle; hi/lo unchanged. Start+flush same cycle → no operation.
- `reset` asserted mid-MULT → next cycle busy=0, hi=lo=0; no late write after reset deasserts.
- With `MD_UNIT_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0. Without it, same stimulus → busy stays 0, registers unchanged.
